// File: rtl/sys_ctrl.sv
// Command-frame controller: collects CMD/A/B/FUN bytes from UART RX, fires the ALU,
// and hands the registered ALU result to UART TX. A frame timeout keeps a truncated frame from hanging the link.
//
// state    | meaning
// ---------+-----------------------------------------------
// IDLE     | waiting for a command byte
// GET_A    | waiting for operand A byte
// GET_B    | waiting for operand B byte
// GET_FUN  | waiting for function byte
// ALU_RUN  | ALU_EN pulse cycle
// WAIT_RES | waiting for ALU_OUT_VLD
// SEND     | holding TX_D_VLD until the transmitter is free
module sys_ctrl #(
   parameter int                    DATA_WIDTH     = 8,
   parameter int                    FUN_WIDTH      = 4,
   parameter int                    TIMEOUT_CYCLES = 1024,
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_OP     = DATA_WIDTH'(8'hCC),
   parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOP    = DATA_WIDTH'(8'hDD)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_DATA,
   input  logic                  RX_D_VLD,
   output logic [DATA_WIDTH-1:0] ALU_A,
   output logic [DATA_WIDTH-1:0] ALU_B,
   output logic [FUN_WIDTH-1:0]  ALU_FUN,
   output logic                  ALU_EN,
   input  logic [DATA_WIDTH-1:0] ALU_OUT,
   input  logic                  ALU_OUT_VLD,
   output logic [DATA_WIDTH-1:0] TX_P_DATA,
   output logic                  TX_D_VLD,
   input  logic                  TX_BUSY,
   output logic                  FRM_ERR
);

   localparam int             TMR_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE, GET_A, GET_B, GET_FUN, ALU_RUN, WAIT_RES, SEND
   } state_t;

   state_t                  state, state_nxt;
   logic [TMR_W-1:0]        tmr, tmr_nxt;
   logic [DATA_WIDTH-1:0]   alu_a_nxt, alu_b_nxt, tx_data_nxt;
   logic [FUN_WIDTH-1:0]    alu_fun_nxt;
   logic                    alu_en_nxt, tx_vld_nxt, frm_err_nxt;
   logic                    timed, tmr_tc;

   assign timed  = (state == GET_A) || (state == GET_B) ||
                   (state == GET_FUN) || (state == WAIT_RES);
   assign tmr_tc = (tmr == '0);

   always_comb begin
      state_nxt   = state;
      alu_a_nxt   = ALU_A;
      alu_b_nxt   = ALU_B;
      alu_fun_nxt = ALU_FUN;
      tx_data_nxt = TX_P_DATA;
      frm_err_nxt = 1'b0;
      tmr_nxt     = tmr;

      // An arriving byte takes priority over a coincident timer expiry.
      case (state)
         IDLE: begin
            if (RX_D_VLD) begin
               if (RX_P_DATA == CMD_ALU_OP)
                  state_nxt = GET_A;
               else if (RX_P_DATA == CMD_ALU_NOP)
                  state_nxt = GET_FUN;
            end
         end
         GET_A: begin
            if (RX_D_VLD) begin
               alu_a_nxt = RX_P_DATA;
               state_nxt = GET_B;
            end else if (tmr_tc) begin
               frm_err_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         GET_B: begin
            if (RX_D_VLD) begin
               alu_b_nxt = RX_P_DATA;
               state_nxt = GET_FUN;
            end else if (tmr_tc) begin
               frm_err_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         GET_FUN: begin
            if (RX_D_VLD) begin
               alu_fun_nxt = RX_P_DATA[FUN_WIDTH-1:0];
               state_nxt   = ALU_RUN;
            end else if (tmr_tc) begin
               frm_err_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         ALU_RUN: state_nxt = WAIT_RES;
         WAIT_RES: begin
            if (ALU_OUT_VLD) begin
               tx_data_nxt = ALU_OUT;
               state_nxt   = SEND;
            end else if (tmr_tc) begin
               frm_err_nxt = 1'b1;
               state_nxt   = IDLE;
            end
         end
         SEND: begin
            if (!TX_BUSY)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase

      // Every accepted byte changes state, so reloading on state entry also covers the per-byte clear.
      if (state_nxt != state)
         tmr_nxt = TMR_LOAD;
      else if (timed)
         tmr_nxt = tmr - TMR_W'(1);

      alu_en_nxt = (state_nxt == ALU_RUN);
      tx_vld_nxt = (state_nxt == SEND);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         tmr       <= '0;
         ALU_A     <= '0;
         ALU_B     <= '0;
         ALU_FUN   <= '0;
         ALU_EN    <= 1'b0;
         TX_P_DATA <= '0;
         TX_D_VLD  <= 1'b0;
         FRM_ERR   <= 1'b0;
      end else begin
         state     <= state_nxt;
         tmr       <= tmr_nxt;
         ALU_A     <= alu_a_nxt;
         ALU_B     <= alu_b_nxt;
         ALU_FUN   <= alu_fun_nxt;
         ALU_EN    <= alu_en_nxt;
         TX_P_DATA <= tx_data_nxt;
         TX_D_VLD  <= tx_vld_nxt;
         FRM_ERR   <= frm_err_nxt;
      end
   end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl with a 1-cycle ALU model and TX/ALU_EN/FRM_ERR event counters.
module tb_sys_ctrl;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [7:0] RX_P_DATA = '0;
   logic       RX_D_VLD = 1'b0;
   logic [7:0] ALU_A, ALU_B, TX_P_DATA;
   logic [3:0] ALU_FUN;
   logic       ALU_EN, TX_D_VLD, FRM_ERR;
   logic [7:0] ALU_OUT = '0;
   logic       ALU_OUT_VLD = 1'b0;
   logic       TX_BUSY = 1'b0;

   int n_chk = 0, n_fail = 0;
   int xfer_cnt = 0, en_cnt = 0, frm_cnt = 0;
   logic [7:0] last_tx = '0;

   sys_ctrl dut (
      .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_EN(ALU_EN),
      .ALU_OUT(ALU_OUT), .ALU_OUT_VLD(ALU_OUT_VLD),
      .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD), .TX_BUSY(TX_BUSY),
      .FRM_ERR(FRM_ERR)
   );

   always #5 CLK = ~CLK;

   // ALU: 0 add, 1 sub, 2 mul, 8 and, 9 or, others 0
   always @(posedge CLK) begin
      ALU_OUT_VLD <= ALU_EN;
      if (ALU_EN) begin
         case (ALU_FUN)
            4'd0:    ALU_OUT <= ALU_A + ALU_B;
            4'd1:    ALU_OUT <= ALU_A - ALU_B;
            4'd2:    ALU_OUT <= ALU_A * ALU_B;
            4'd8:    ALU_OUT <= ALU_A & ALU_B;
            4'd9:    ALU_OUT <= ALU_A | ALU_B;
            default: ALU_OUT <= 8'h00;
         endcase
      end
   end

   always @(posedge CLK) begin
      if (TX_D_VLD && !TX_BUSY) begin
         xfer_cnt <= xfer_cnt + 1;
         last_tx  <= TX_P_DATA;
      end
      if (ALU_EN)  en_cnt  <= en_cnt + 1;
      if (FRM_ERR) frm_cnt <= frm_cnt + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Strobe one byte for one cycle; returns at the negedge after the sampling edge.
   task automatic send_byte(input logic [7:0] b);
      RX_P_DATA = b;
      RX_D_VLD  = 1'b1;
      @(negedge CLK);
      RX_D_VLD  = 1'b0;
   endtask

   task automatic expect_tx(input string tag, input logic [7:0] exp);
      int base;
      bit seen;
      base = xfer_cnt;
      seen = 1'b0;
      for (int i = 0; i < 30 && !seen; i++) begin
         @(negedge CLK);
         if (xfer_cnt != base) seen = 1'b1;
      end
      chk({tag, "_seen"}, 32'(seen), 32'd1);
      chk({tag, "_byte"}, 32'(last_tx), 32'(exp));
      repeat (3) @(negedge CLK);
      chk({tag, "_once"}, 32'(xfer_cnt - base), 32'd1);
   endtask

   initial begin
      int en0, frm0, x0;
      #2 RST = 1'b0;
      #1;
      chk("rst_a", 32'(ALU_A), 0);
      chk("rst_en_tx_err", {29'd0, ALU_EN, TX_D_VLD, FRM_ERR}, 0);
      chk("rst_tx_data", 32'(TX_P_DATA), 0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // Frame 1 with exact latency
      en0 = en_cnt; x0 = xfer_cnt;
      send_byte(8'hCC); send_byte(8'h05); send_byte(8'h03); send_byte(8'h00);
      chk("f1_ops", {16'd0, ALU_A, ALU_B}, 32'h0503);
      chk("f1_fun", 32'(ALU_FUN), 0);
      chk("f1_en_n1", 32'(ALU_EN), 1);
      @(negedge CLK);
      chk("f1_en_n2", 32'(ALU_EN), 0);
      chk("f1_txv_n2", 32'(TX_D_VLD), 0);
      @(negedge CLK);
      chk("f1_txv_n3", 32'(TX_D_VLD), 1);
      chk("f1_txd_n3", 32'(TX_P_DATA), 32'h08);
      @(negedge CLK);
      chk("f1_txv_n4", 32'(TX_D_VLD), 0);
      chk("f1_en_cnt", 32'(en_cnt - en0), 1);
      chk("f1_xfer", 32'(xfer_cnt - x0), 1);

      // NOP frames reuse operands; upper FUN bits dropped
      send_byte(8'hDD); send_byte(8'h02);
      chk("nop1_ops", {8'd0, ALU_A, ALU_B, 4'd0, ALU_FUN}, 32'h050302);
      expect_tx("nop1", 8'h0F);
      send_byte(8'hDD); send_byte(8'hF9);
      chk("nop2_fun", 32'(ALU_FUN), 9);
      expect_tx("nop2", 8'h07);

      // Non-command bytes in IDLE ignored
      en0 = en_cnt;
      send_byte(8'h7A); send_byte(8'h11);
      repeat (3) @(negedge CLK);
      chk("junk_en", 32'(en_cnt - en0), 0);
      chk("junk_a", 32'(ALU_A), 32'h05);
      send_byte(8'hCC); send_byte(8'h0A); send_byte(8'h04); send_byte(8'h01);
      expect_tx("sub", 8'h06);

      // Timeout in GET_B: FRM_ERR on the 1024th idle cycle
      en0 = en_cnt; frm0 = frm_cnt;
      send_byte(8'hCC); send_byte(8'h05);
      repeat (1023) @(negedge CLK);
      chk("to_early", 32'(FRM_ERR), 0);
      @(negedge CLK);
      chk("to_pulse", 32'(FRM_ERR), 1);
      @(negedge CLK);
      chk("to_single", 32'(FRM_ERR), 0);
      chk("to_cnt", 32'(frm_cnt - frm0), 1);
      chk("to_ops", {16'd0, ALU_A, ALU_B}, 32'h0504);
      chk("to_no_en", 32'(en_cnt - en0), 0);
      send_byte(8'hDD); send_byte(8'h00);
      expect_tx("to_nop", 8'h09);

      // Byte arriving on the expiry cycle wins
      frm0 = frm_cnt;
      send_byte(8'hCC);
      repeat (1023) @(negedge CLK);
      send_byte(8'h06);
      repeat (1023) @(negedge CLK);
      send_byte(8'h02); send_byte(8'h00);
      expect_tx("edge", 8'h08);
      chk("edge_no_err", 32'(frm_cnt - frm0), 0);

      // TX busy hold with a dropped RX byte
      TX_BUSY = 1'b1;
      x0 = xfer_cnt;
      send_byte(8'hCC); send_byte(8'h20); send_byte(8'h03); send_byte(8'h01);
      for (int i = 0; i < 20 && !TX_D_VLD; i++) @(negedge CLK);
      chk("busy_vld", 32'(TX_D_VLD), 1);
      begin
         int bad = 0;
         for (int i = 0; i < 50; i++) begin
            if (i == 10) send_byte(8'hCC);
            else @(negedge CLK);
            if (!TX_D_VLD || TX_P_DATA !== 8'h1D) bad++;
         end
         chk("busy_stable", 32'(bad), 0);
      end
      chk("busy_no_xfer", 32'(xfer_cnt - x0), 0);
      TX_BUSY = 1'b0;
      @(negedge CLK);
      chk("busy_done_vld", 32'(TX_D_VLD), 0);
      chk("busy_xfer", 32'(xfer_cnt - x0), 1);
      chk("busy_byte", 32'(last_tx), 32'h1D);
      send_byte(8'hDD); send_byte(8'h00);
      expect_tx("busy_idle", 8'h23);

      // Async reset in GET_B
      send_byte(8'hCC); send_byte(8'h11);
      #2 RST = 1'b0;
      #1;
      chk("rstb_a", 32'(ALU_A), 0);
      chk("rstb_ctl", {29'd0, ALU_EN, TX_D_VLD, FRM_ERR}, 0);
      @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);

      // Async reset in SEND
      TX_BUSY = 1'b1;
      x0 = xfer_cnt;
      send_byte(8'hCC); send_byte(8'h03); send_byte(8'h04); send_byte(8'h00);
      for (int i = 0; i < 20 && !TX_D_VLD; i++) @(negedge CLK);
      chk("rsts_pre", {23'd0, TX_D_VLD, TX_P_DATA}, 32'h107);
      #2 RST = 1'b0;
      #1;
      chk("rsts_tx", {23'd0, TX_D_VLD, TX_P_DATA}, 0);
      chk("rsts_ops", {12'd0, ALU_A, ALU_B, ALU_FUN}, 0);
      @(negedge CLK);
      RST = 1'b1;
      TX_BUSY = 1'b0;
      @(negedge CLK);
      send_byte(8'hCC); send_byte(8'h02); send_byte(8'h02); send_byte(8'h00);
      expect_tx("post_rst", 8'h04);
      chk("post_rst_total", 32'(xfer_cnt - x0), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed time limit expired, required end of test");
      $fatal(1, "watchdog");
   end

endmodule
